// File: rtl/mul_column_feed_ctrl.sv
// Operand sequencer for the column-compressor multiplier: streams each column's
// partial-product bits into its shift register, then captures the settled product.
module mul_column_feed_ctrl #(
    parameter int W          = 32,
    parameter int OUT_STAGES = 0,
    parameter int CNT_W      = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       in_a,
    input  logic [W-1:0]       in_b,
    output logic [2*W-2:0]     col_bit,
    input  logic [2*W-1:0]     dst_bits,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*W-1:0]     out_product,
    output logic               busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_k;
    logic [CNT_W-1:0] r_settle;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;

    logic             w_accept;
    logic             w_load_last;
    logic             w_settle_last;
    logic             w_feed;
    logic [W-1:0]     w_src_a;
    logic [W-1:0]     w_src_b;
    logic [CNT_W-1:0] w_k_sel;
    logic [W-1:0]     w_k_onehot;
    logic [2*W-2:0]   w_col_nxt;

    assign w_accept      = (r_state == S_IDLE) && in_valid;
    assign w_load_last   = (r_state == S_LOAD) && (r_k == CNT_W'(W - 1));
    assign w_settle_last = (r_state == S_SETTLE) && (r_settle == CNT_W'(OUT_STAGES));

    // col_bit is registered, so it is computed one cycle ahead: the accepting
    // edge loads cycle k=0 straight from the input operands.
    assign w_feed     = w_accept || ((r_state == S_LOAD) && !w_load_last);
    assign w_src_a    = (r_state == S_IDLE) ? in_a : r_a;
    assign w_src_b    = (r_state == S_IDLE) ? in_b : r_b;
    assign w_k_sel    = (r_state == S_IDLE) ? '0 : (r_k + CNT_W'(1));
    assign w_k_onehot = {{(W-1){1'b0}}, 1'b1} << w_k_sel;

    for (genvar c = 0; c < 2*W-1; c++) begin : g_col
        localparam int H   = (c + 1 < 2*W - 1 - c) ? (c + 1) : (2*W - 1 - c);
        localparam int RLO = (c - W + 1 > 0) ? (c - W + 1) : 0;
        localparam int OFF = W - H;
        logic [W-1:0] w_elem;
        for (genvar k = 0; k < W; k++) begin : g_k
            if (k < OFF) begin : g_zero
                assign w_elem[k] = 1'b0;
            end else begin : g_pp
                assign w_elem[k] = w_src_a[c - RLO - (k - OFF)] & w_src_b[RLO + (k - OFF)];
            end
        end
        assign w_col_nxt[c] = w_feed & (|(w_elem & w_k_onehot));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        busy        = 1'b1;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_load_last) begin
                    w_state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (w_settle_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_k         <= '0;
            r_settle    <= '0;
            col_bit     <= '0;
            out_valid   <= 1'b0;
            out_product <= '0;
        end else begin
            col_bit <= w_col_nxt;

            if ((r_state == S_LOAD) && !w_load_last) begin
                r_k <= r_k + CNT_W'(1);
            end else begin
                r_k <= '0;
            end

            if ((r_state == S_SETTLE) && !w_settle_last) begin
                r_settle <= r_settle + CNT_W'(1);
            end else begin
                r_settle <= '0;
            end

            // The compressor output is only trustworthy on this one edge;
            // later zero-shifts corrupt the column registers.
            if (w_settle_last) begin
                out_product <= dst_bits;
                out_valid   <= 1'b1;
            end else if ((r_state == S_DONE) && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a <= in_a;
            r_b <= in_b;
        end
    end

endmodule

// File: tb/tb_mul_column_feed_ctrl.sv
// Bench for mul_column_feed_ctrl: models the column shift registers and compressor,
// runs a vector table through a scoreboard, plus reset-abort and OUT_STAGES=2 cases.
module tb_mul_column_feed_ctrl;

    localparam int W  = 32;
    localparam int NC = 2*W - 1;

    typedef logic [2*W-1:0] prod_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        prod_t        exp;
        int           bp;
        bit           colchk;
        bit           poke;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic           in_valid, in_ready, out_valid, out_ready, busy;
    logic [W-1:0]   in_a, in_b;
    logic [NC-1:0]  col_bit;
    prod_t          dst_bits, out_product;

    logic           in_valid2, in_ready2, out_valid2, out_ready2, busy2;
    logic [W-1:0]   in_a2, in_b2;
    logic [NC-1:0]  col_bit2;
    prod_t          dst_bits2, out_product2;

    mul_column_feed_ctrl #(.W(W), .OUT_STAGES(0), .CNT_W(6)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .col_bit(col_bit), .dst_bits(dst_bits),
        .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product),
        .busy(busy)
    );

    mul_column_feed_ctrl #(.W(W), .OUT_STAGES(2), .CNT_W(6)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_a(in_a2), .in_b(in_b2), .col_bit(col_bit2), .dst_bits(dst_bits2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_product(out_product2),
        .busy(busy2)
    );

    function automatic int hgt(int c);
        return (c + 1 < 2*W - 1 - c) ? (c + 1) : (2*W - 1 - c);
    endfunction

    // Datapath model: per-column shift registers (never reset) and a compressor
    // that sums each column's h(c) newest bits at weight 2^c.
    logic [W-1:0] sr0 [NC];
    logic [W-1:0] sr2 [NC];
    prod_t        comp2, pipe1, pipe2;

    always @(posedge clk) begin
        for (int c = 0; c < NC; c++) begin
            sr0[c] <= {sr0[c][W-2:0], col_bit[c]};
            sr2[c] <= {sr2[c][W-2:0], col_bit2[c]};
        end
        pipe1 <= comp2;
        pipe2 <= pipe1;
    end

    always_comb begin
        dst_bits = '0;
        comp2    = '0;
        for (int c = 0; c < NC; c++) begin
            for (int m = 0; m < W; m++) begin
                if (m < hgt(c)) begin
                    dst_bits = dst_bits + (prod_t'(sr0[c][m]) << c);
                    comp2    = comp2 + (prod_t'(sr2[c][m]) << c);
                end
            end
        end
    end

    assign dst_bits2 = pipe2;

    int    n_checks = 0;
    int    n_fail   = 0;
    prod_t exp_q[$];

    task automatic check(input string name, input prod_t act, input prod_t req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: every output handshake pops one expected product.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output actual=0x%0h required=none", out_product);
            end else begin
                check("product", out_product, exp_q.pop_front());
            end
        end
    end

    task automatic run_op(input vec_t v);
        int    cnt;
        int    col_err;
        int    ones;
        int    side_err;
        int    bp_err;
        prod_t held;
        cnt = 0;
        while (!in_ready && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("in_ready_before_accept", prod_t'(in_ready), 1);
        in_valid = 1'b1;
        in_a     = v.a;
        in_b     = v.b;
        exp_q.push_back(v.exp);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a     = ~v.a;
        in_b     = $urandom;
        cnt      = 0;
        col_err  = 0;
        ones     = 0;
        side_err = 0;
        while (!out_valid && cnt < 200) begin
            if (v.colchk) begin
                if (col_bit !== ((cnt == W-1) ? NC'(1) : NC'(0))) col_err++;
                if (col_bit[0]) ones++;
            end
            if (in_ready || !busy) side_err++;
            if (v.poke && cnt == 5) begin
                in_valid = 1'b1;
                in_a     = $urandom;
                in_b     = $urandom;
            end
            if (v.poke && cnt == 7) in_valid = 1'b0;
            @(posedge clk); #1;
            cnt++;
        end
        check("latency", prod_t'(cnt), prod_t'(W + 1));
        check("busy_not_ready_while_running", prod_t'(side_err), 0);
        if (v.colchk) begin
            if (col_bit !== '0) col_err++;
            check("col_bit_pattern_errors", prod_t'(col_err), 0);
            check("col_bit0_high_cycles", prod_t'(ones), 1);
        end
        held   = out_product;
        bp_err = 0;
        for (int j = 0; j < v.bp; j++) begin
            in_valid = 1'b1;
            @(posedge clk); #1;
            if (!out_valid || out_product !== held || in_ready) bp_err++;
        end
        in_valid = 1'b0;
        if (v.bp > 0) check("backpressure_stability_errors", prod_t'(bp_err), 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid_after_handshake", prod_t'(out_valid), 0);
        check("in_ready_after_handshake", prod_t'(in_ready), 1);
        check("product_kept_after_handshake", out_product, v.exp);
    endtask

    vec_t vecs[8];

    initial begin
        int cnt;
        logic [W-1:0] ra, rb;

        vecs[0] = '{32'd3, 32'd5, 64'h000000000000000F, 0, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 0, 1'b0, 1'b0};
        vecs[2] = '{32'h80000000, 32'd2, 64'h0000000100000000, 10, 1'b0, 1'b0};
        vecs[3] = '{32'd1, 32'd1, 64'h1, 0, 1'b1, 1'b0};
        vecs[4] = '{32'h12345678, 32'h9ABCDEF0, 64'h0B00EA4E242D2080, 0, 1'b0, 1'b1};
        vecs[5] = '{32'd0, 32'hFFFFFFFF, 64'h0, 2, 1'b0, 1'b0};
        for (int i = 6; i < 8; i++) begin
            ra = $urandom;
            rb = $urandom;
            vecs[i] = '{ra, rb, prod_t'(ra) * prod_t'(rb), 3, 1'b0, 1'b0};
        end

        rst        = 1'b1;
        in_valid   = 1'b0;
        in_a       = '0;
        in_b       = '0;
        out_ready  = 1'b0;
        in_valid2  = 1'b0;
        in_a2      = '0;
        in_b2      = '0;
        out_ready2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", prod_t'(in_ready), 1);
        check("reset_busy", prod_t'(busy), 0);
        check("reset_out_valid", prod_t'(out_valid), 0);
        check("reset_out_product", out_product, 0);
        check("reset_col_bit", prod_t'(col_bit), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) run_op(vecs[i]);

        // Abort mid-LOAD at k=12; nothing may come out, next op must be clean.
        in_valid = 1'b1;
        in_a     = 32'hDEADBEEF;
        in_b     = 32'hF00DCAFE;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("busy_before_abort", prod_t'(busy), 1);
        rst = 1'b1;
        #1;
        check("abort_busy", prod_t'(busy), 0);
        check("abort_in_ready", prod_t'(in_ready), 1);
        check("abort_col_bit", prod_t'(col_bit), 0);
        check("abort_out_valid", prod_t'(out_valid), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("no_output_after_abort", prod_t'(out_valid), 0);
        run_op('{32'd7, 32'd9, 64'd63, 0, 1'b0, 1'b0});

        // OUT_STAGES=2 instance.
        in_valid2 = 1'b1;
        in_a2     = 32'h12345678;
        in_b2     = 32'h9ABCDEF0;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        in_a2     = '0;
        cnt       = 0;
        while (!out_valid2 && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("stages2_latency", prod_t'(cnt), prod_t'(W + 3));
        check("stages2_product", out_product2, 64'h0B00EA4E242D2080);
        out_ready2 = 1'b1;
        @(posedge clk); #1;
        out_ready2 = 1'b0;
        check("stages2_out_valid_cleared", prod_t'(out_valid2), 0);
        check("stages2_in_ready", prod_t'(in_ready2), 1);

        check("scoreboard_drained", prod_t'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_column_feed_ctrl.md
Name: mul_column_feed_ctrl

Overview:
- Sequencer for the column-compressor multiplier datapath. A per-column bit shift register feeds the compressor: column c, height h(c) = min(c+1, 2W-1-c), shifts one bit per clk with no enable.
- Accepts one operand pair over a valid/ready handshake and streams each column's partial-product bits serially into the shift-register inputs.
- Captures the compressor result once it has settled and returns it over a valid/ready output handshake.
- One multiplication in flight at a time.

Parameters:
W, 32, operand width; the datapath has 2W-1 input columns and 2W result bits.
OUT_STAGES, 0, pipeline register stages between the compressor outputs and dst_bits (0 = combinational).
CNT_W, 6, counter width; must satisfy 2^CNT_W > max(W, OUT_STAGES+1).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  operand pair valid.
in_ready  out  1  high only in IDLE.
in_a  in  W  multiplicand.
in_b  in  W  multiplier.
col_bit  out  2W-1  bit c drives shift-register input src<c>_.
dst_bits  in  2W  bit i from compressor output dst<i>, after OUT_STAGES registers.
out_valid  out  1  product valid.
out_ready  in  1  consumer accepts product.
out_product  out  2W  captured product.
busy  out  1  high in any state other than IDLE.

Behaviour:
- States and transitions:
  - IDLE: transitions to LOAD when in_valid & in_ready.
  - LOAD: lasts exactly W cycles, k = 0..W-1.
  - SETTLE: lasts exactly OUT_STAGES+1 cycles.
  - DONE: transitions to IDLE when out_ready is sampled high.
- Reset values (applied asynchronously): state=IDLE, k=0, settle counter=0, col_bit=0, out_valid=0, out_product=0, busy=0, in_ready=1 once rst is released.
- Accept: in_a and in_b are latched into internal registers on the accepting edge. Operands are not sampled again until the next IDLE.
- Column ordering:
  - rlo(c) = max(0, c-W+1).
  - Element m of column c = a[c-rlo(c)-m] & b[rlo(c)+m], for m = 0..h(c)-1.
- LOAD drive rule, cycle k, column c:
  - col_bit[c] = 0 if k < W-h(c).
  - Otherwise col_bit[c] = element m = k-(W-h(c)).
  - col_bit is registered: its value for cycle k is visible throughout cycle k and is shifted in at the edge ending cycle k.
- After the W-th LOAD edge every column register holds exactly its h(c) elements. Stale contents are fully overwritten, so no flush is required.
- col_bit = 0 in every state other than LOAD.
- Capture:
  - The compressor is combinational, so the shift registers are valid only for the single cycle after the last LOAD edge; later zero-shifts corrupt them.
  - The pipeline registers (if any) sample dst at that edge, so the correct value reaches dst_bits OUT_STAGES cycles later.
  - SETTLE counts OUT_STAGES+1 cycles and latches dst_bits into out_product on its final edge. The same edge sets out_valid=1 and moves to DONE.
- Latency: out_valid rises W+OUT_STAGES+1 clock edges after the accepting edge (33 for the defaults).
- DONE:
  - out_valid and out_product are held stable until out_ready is sampled high.
  - On that edge: out_valid=0, state=IDLE.
  - out_product keeps its last value after the handshake.
- Back-to-back: in_ready rises the cycle after the output handshake. There is no bypass from DONE to LOAD.
- Ignored inputs: in_valid outside IDLE is ignored, as is out_ready outside DONE.
- Reset mid-operation: abort immediately to IDLE with col_bit=0. No result is produced. The next accepted operation is correct without a flush.

Test Plan:
- Direct col_bit check, W=32: a=1, b=1 → col_bit[0]=1 only in LOAD cycle k=31; all other col_bit bits are 0 in every cycle.
- Full datapath (shift register + compressor), W=32, OUT_STAGES=0: a=3, b=5 → out_valid 33 edges after accept, out_product=0x000000000000000F.
- a=b=0xFFFFFFFF → out_product=0xFFFFFFFE00000001. Then a=0x80000000, b=2 → 0x0000000100000000.
- Backpressure: out_ready held low for 10 cycles → out_valid and out_product stable and in_ready=0 throughout. out_ready pulse → IDLE next cycle; a new in_valid is accepted the following edge.
- Assert rst at LOAD k=12 → state IDLE and col_bit=0 immediately. Then 7×9 → out_product=63 with no residue from the aborted pair.
- OUT_STAGES=2 build with 2 register stages inserted: 0x12345678 × 0x9ABCDEF0 → 0x0B00EA4E242D2080, out_valid 35 edges after accept.
